// File: rtl/seq_gen_if.sv
// Control/stream bundle for seq_gen: the requester drives start/abort/pattern
// selection, the generator returns the serial stream and its status flags.
interface seq_gen_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             abort;
    logic             pat_sel;
    logic [WIDTH-1:0] pattern_in;
    logic [3:0]       reps;
    logic             out;
    logic             valid;
    logic             busy;
    logic             done;

    modport master (
        output start, abort, pat_sel, pattern_in, reps,
        input  out, valid, busy, done
    );

    modport slave (
        input  start, abort, pat_sel, pattern_in, reps,
        output out, valid, busy, done
    );
endinterface

// File: rtl/seq_gen.sv
// Serial pattern generator: sends a WIDTH-bit pattern MSB first, reps times.
// Define SEQ_GEN_GAP_EN to insert one gap cycle (out=1, valid=0) between repetitions.
module seq_gen #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] DEF_PAT = WIDTH'(4'b0110)
) (
    input  logic     clk,
    input  logic     reset_n,
    seq_gen_if.slave bus
);

    localparam int               IDX_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
`ifdef SEQ_GEN_GAP_EN
        GAP  = 2'd3,
`endif
        FIN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [3:0]       rep_q, rep_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic             out_q, out_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] sel_pat;

    assign sel_pat = bus.pat_sel ? bus.pattern_in : DEF_PAT;

    // Outputs are registered, so each next-state decision also computes
    // the bit that will be on the wire during the following cycle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rep_d   = rep_q;
        pat_d   = pat_q;
        out_d   = 1'b0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_d = SEND;
                    pat_d   = sel_pat;
                    rep_d   = (bus.reps == 4'd0) ? 4'd1 : bus.reps;
                    idx_d   = IDX_MAX;
                    out_d   = sel_pat[WIDTH-1];
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end

            SEND: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (idx_q != '0) begin
                    idx_d   = idx_q - 1'b1;
                    out_d   = pat_q[idx_q - 1'b1];
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end else if (rep_q > 4'd1) begin
                    rep_d   = rep_q - 4'd1;
`ifdef SEQ_GEN_GAP_EN
                    state_d = GAP;
                    out_d   = 1'b1;
                    busy_d  = 1'b1;
`else
                    idx_d   = IDX_MAX;
                    out_d   = pat_q[WIDTH-1];
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
`endif
                end else begin
                    state_d = FIN;
                    done_d  = 1'b1;
                end
            end

`ifdef SEQ_GEN_GAP_EN
            GAP: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else begin
                    state_d = SEND;
                    idx_d   = IDX_MAX;
                    out_d   = pat_q[WIDTH-1];
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
`endif

            FIN: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            rep_q   <= '0;
            pat_q   <= '0;
            out_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rep_q   <= rep_d;
            pat_q   <= pat_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.out   = out_q;
    assign bus.valid = valid_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

endmodule
